// File: rtl/pzc_reco_pkg.sv
// Shared definitions for the PZC energy reconstruction chain:
// matched-filter coefficients, peak-finder state encoding and the
// output FIFO entry layout.
package pzc_reco_pkg;

    // Matched-filter taps, C0 applies to the newest sample.
    localparam int C0 = -512;
    localparam int C1 = 2048;
    localparam int C2 = 4096;
    localparam int C3 = 2048;
    localparam int C4 = -512;

    localparam int RECO_NTAPS    = 5;
    localparam int RECO_ENERGY_W = 13;
    localparam int RECO_BCID_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        DEAD = 2'd2
    } reco_state_t;

    typedef struct packed {
        logic [RECO_ENERGY_W-1:0] energy;
        logic [RECO_BCID_W-1:0]   bcid;
    } reco_entry_t;

endpackage

// File: rtl/reco_fifo.sv
// First-word-fall-through FIFO with occupancy and sticky overflow flag.
// A push while full is dropped unless a pop happens in the same cycle.
module reco_fifo #(
    parameter int DATA_W = 25,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop_ready,
    input  logic                     ovf_clear,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              empty, full, pop, accept, drop;

    assign empty  = (level_q == '0);
    assign full   = (level_q == FULL_LVL);
    assign pop    = !empty && pop_ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Next-state for storage, pointers, occupancy and the sticky drop flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (accept) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !accept) begin
            level_d = level_q - (AW+1)'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/pzc_energy_reco.sv
// PZC energy reconstruction: 5-tap matched FIR, scale/saturate,
// peak finder with dead time, BCID tagging and an FWFT output FIFO.
// Optional macro PZC_RECO_BT_GATE_EN: drop detections whose peak sample
// was outside the bunch-train mask (bt_mask_in travels with the tag).
module pzc_energy_reco
    import pzc_reco_pkg::*;
#(
    parameter int NBITS_IN   = 29,
    parameter int NBITS_OUT  = 13,
    parameter int COEF_BITS  = 16,
    parameter int SHIFT_OUT  = 16,
    parameter int THRESH     = 64,
    parameter int DEAD_TIME  = 4,
    parameter int BUNCH_POS  = 3564,
    parameter int BCID_BITS  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [NBITS_IN-1:0]    in_sample,
    input  logic                          bcr,
    input  logic                          bt_mask_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NBITS_OUT-1:0]          out_energy,
    output logic [BCID_BITS-1:0]          out_bcid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_overflow,
    input  logic                          ovf_clear
);

    localparam int SUM_W = NBITS_IN + COEF_BITS + 3;
    localparam int CNT_W = $clog2(DEAD_TIME + 2);
    localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'((2**NBITS_OUT) - 1);
    localparam logic [NBITS_OUT-1:0] THRESH_Y = NBITS_OUT'(THRESH);
    localparam logic [CNT_W-1:0]     DEAD_CNT = CNT_W'(DEAD_TIME);
    localparam logic [BCID_BITS-1:0] BCID_LAST = BCID_BITS'(BUNCH_POS - 1);
    localparam logic signed [COEF_BITS-1:0] COEF [RECO_NTAPS] = '{
        COEF_BITS'(C0), COEF_BITS'(C1), COEF_BITS'(C2), COEF_BITS'(C3), COEF_BITS'(C4)
    };

    logic signed [NBITS_IN-1:0] x_q [RECO_NTAPS];
    logic signed [NBITS_IN-1:0] x_d [RECO_NTAPS];
    logic signed [SUM_W-1:0]    sum_q, sum_d, shifted;
    logic [NBITS_OUT-1:0]       y_q, y_d;
    logic [BCID_BITS-1:0]       bcid_q, bcid_d;
    logic [BCID_BITS-1:0]       tag0_q, tag1_q, ytag_q;
    reco_state_t                state_q, state_d;
    logic [NBITS_OUT-1:0]       peak_q, peak_d;
    logic [BCID_BITS-1:0]       peak_tag_q, peak_tag_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       detect, push;
    reco_entry_t                push_entry, head;
    logic [$bits(reco_entry_t)-1:0] head_bits;

`ifdef PZC_RECO_BT_GATE_EN
    logic mask0_q, mask1_q, ymask_q, peak_mask_q, peak_mask_d;
`else
    logic unused_bt_mask;
    assign unused_bt_mask = bt_mask_in;
`endif

    // Bunch counter: bcr forces zero, otherwise count modulo BUNCH_POS.
    always_comb begin
        if (bcr) begin
            bcid_d = '0;
        end else if (bcid_q == BCID_LAST) begin
            bcid_d = '0;
        end else begin
            bcid_d = bcid_q + BCID_BITS'(1);
        end
    end

    // Delay line: newest sample in tap 0.
    always_comb begin
        x_d[0] = in_sample;
        for (int unsigned k = 1; k < RECO_NTAPS; k++) begin
            x_d[k] = x_q[k-1];
        end
    end

    // Full-precision matched-filter sum.
    always_comb begin
        sum_d = '0;
        for (int unsigned k = 0; k < RECO_NTAPS; k++) begin
            sum_d = sum_d + SUM_W'(x_q[k]) * SUM_W'(COEF[k]);
        end
    end

    // Scale and clamp into the unsigned energy range.
    always_comb begin
        shifted = sum_q >>> SHIFT_OUT;
        if (shifted[SUM_W-1]) begin
            y_d = '0;
        end else if (shifted > Y_MAX) begin
            y_d = '1;
        end else begin
            y_d = shifted[NBITS_OUT-1:0];
        end
    end

    // Peak finder: first sample not above the running peak emits it.
    always_comb begin
        state_d    = state_q;
        peak_d     = peak_q;
        peak_tag_d = peak_tag_q;
        cnt_d      = cnt_q;
        detect     = 1'b0;
`ifdef PZC_RECO_BT_GATE_EN
        peak_mask_d = peak_mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (y_q >= THRESH_Y) begin
                    state_d    = RISE;
                    peak_d     = y_q;
                    peak_tag_d = ytag_q;
`ifdef PZC_RECO_BT_GATE_EN
                    peak_mask_d = ymask_q;
`endif
                end
            end
            RISE: begin
                if (y_q > peak_q) begin
                    peak_d     = y_q;
                    peak_tag_d = ytag_q;
`ifdef PZC_RECO_BT_GATE_EN
                    peak_mask_d = ymask_q;
`endif
                end else begin
                    detect = 1'b1;
                    if (DEAD_TIME == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DEAD;
                        cnt_d   = DEAD_CNT;
                    end
                end
            end
            DEAD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PZC_RECO_BT_GATE_EN
    assign push = detect && peak_mask_q;
`else
    assign push = detect;
`endif

    // Datapath pipeline, tag pipeline and FSM registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < RECO_NTAPS; k++) begin
                x_q[k] <= '0;
            end
            sum_q      <= '0;
            y_q        <= '0;
            bcid_q     <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            ytag_q     <= '0;
            state_q    <= IDLE;
            peak_q     <= '0;
            peak_tag_q <= '0;
            cnt_q      <= '0;
        end else begin
            x_q        <= x_d;
            sum_q      <= sum_d;
            y_q        <= y_d;
            bcid_q     <= bcid_d;
            tag0_q     <= bcid_q;
            tag1_q     <= tag0_q;
            ytag_q     <= tag1_q;
            state_q    <= state_d;
            peak_q     <= peak_d;
            peak_tag_q <= peak_tag_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef PZC_RECO_BT_GATE_EN
    // Bunch-train mask travels alongside the BCID tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask0_q     <= 1'b0;
            mask1_q     <= 1'b0;
            ymask_q     <= 1'b0;
            peak_mask_q <= 1'b0;
        end else begin
            mask0_q     <= bt_mask_in;
            mask1_q     <= mask0_q;
            ymask_q     <= mask1_q;
            peak_mask_q <= peak_mask_d;
        end
    end
`endif

    assign push_entry = '{energy: RECO_ENERGY_W'(peak_q), bcid: RECO_BCID_W'(peak_tag_q)};

    reco_fifo #(
        .DATA_W ($bits(reco_entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_entry),
        .pop_ready (out_ready),
        .ovf_clear (ovf_clear),
        .out_valid (out_valid),
        .out_data  (head_bits),
        .level     (fifo_level),
        .overflow  (fifo_overflow)
    );

    assign head       = head_bits;
    assign out_energy = NBITS_OUT'(head.energy);
    assign out_bcid   = BCID_BITS'(head.bcid);

endmodule

// File: doc/pzc_energy_reco.md
Name: pzc_energy_reco

Overview:
- Receiving end of the simulator chain: consumes the signed pedestal-corrected sample stream (one sample per clk) and reconstructs per-pulse energy.
- Datapath: 5-tap FIR matched filter, then scale/saturate, then peak-finder FSM with dead time.
- Each detection is tagged with its bunch-crossing ID (BCID) and buffered in a small FWFT FIFO with valid/ready output.

Parameters:
- NBITS_IN, 29, width of the signed input sample
- NBITS_OUT, 13, width of the unsigned energy output
- COEF_BITS, 16, width of the signed FIR coefficients
- SHIFT_OUT, 16, arithmetic right shift applied to the FIR sum
- THRESH, 64, minimum scaled value that starts a pulse
- DEAD_TIME, 4, cycles ignored after each emission
- BUNCH_POS, 3564, BCID modulus
- BCID_BITS, 12, BCID width
- FIFO_DEPTH, 4, output FIFO entries (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_sample  in  NBITS_IN  signed sample, valid every cycle
- bcr  in  1  synchronous bunch-counter reset
- bt_mask_in  in  1  bunch-train mask aligned with in_sample (used only by the optional feature)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_energy  out  NBITS_OUT  head energy
- out_bcid  out  BCID_BITS  head BCID
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupancy
- fifo_overflow  out  1  sticky drop flag
- ovf_clear  in  1  clears fifo_overflow

Behaviour:
- Reset (rst=0, asynchronous): all delay taps, FIR and scaled registers, BCID counter, FSM (IDLE), dead counter and FIFO pointers go to 0. Outputs are all 0: out_valid, out_energy, out_bcid, fifo_level, fifo_overflow.
- BCID counter:
  - Increments every cycle and wraps from BUNCH_POS-1 to 0.
  - bcr=1 loads 0 on the next edge; bcr has priority over the increment.
- Cycle t: in_sample enters tap x0, shifting x0..x4. The current BCID is captured alongside the sample.
- t+1: FIR sum S = sum c_k*x_k, full precision, width NBITS_IN+COEF_BITS+3, registered.
- t+2: y = S >>> SHIFT_OUT, then saturated to [0, 2^NBITS_OUT-1] (negative gives 0), registered. The tag is the BCID of the newest sample x0 contributing to y.
- FSM, evaluated on each y:
  - IDLE: if y >= THRESH, go to RISE and store peak=y and its tag.
  - RISE: if y > peak, update peak and tag and stay. If y <= peak, push {peak, tag} into the FIFO. Then go to DEAD with cnt=DEAD_TIME, or to IDLE if DEAD_TIME=0.
  - A plateau (y == peak) emits the first sample of the plateau.
  - DEAD: y is ignored; cnt decrements each cycle; go to IDLE when cnt reaches 1.
- FIFO (FWFT):
  - out_valid = not empty; the head is on out_energy and out_bcid.
  - Pop when out_valid && out_ready.
  - Push while full without a simultaneous pop: the entry is dropped and fifo_overflow is set.
  - Push and pop in the same cycle while full: both proceed, no drop.
  - Empty: out_energy and out_bcid drive 0.
  - ovf_clear clears the flag; a same-cycle drop wins.
- Latency: from the falling sample entering in_sample to out_valid rising on an empty FIFO is 4 cycles.
- bcr mid-pulse: tags already captured are unaffected.

Optional Feature:
- Macro PZC_RECO_BT_GATE_EN.
- Enabled: bt_mask_in is delayed with the BCID tag. A push is suppressed when the peak's aligned mask bit is 0. The FSM still enters DEAD.
- Disabled: bt_mask_in is unused and every detection is pushed.

Decomposition:
- Package pzc_reco_pkg holds:
  - the coefficient constants C0..C4 = -512, 2048, 4096, 2048, -512
  - the FSM state enum (IDLE, RISE, DEAD)
  - the FIFO entry struct {energy, bcid}
- One sub-module, reco_fifo: parameterised FWFT FIFO with level and overflow outputs.

Test Plan:
- Impulse in_sample=65536 at BCID 100, zeros elsewhere -> y sequence 0, 2048, 4096, 2048, 0 -> exactly one entry: energy 4096, bcid 102.
- Impulse of 2^24 -> y saturates at 8191 on three consecutive samples -> one entry: energy 8191, tag of the first saturated sample.
- Impulse of 65536*(THRESH-1)/4096, scaled so the peak is 63 -> no entry; then a peak of exactly 64 -> entry emitted.
- Two impulses of 65536 two cycles apart, DEAD_TIME=4 -> only the first is reported. With 10 cycles apart -> two entries, bcid delta 10.
- out_ready=0 with 6 pulses -> fifo_level saturates at 4 and fifo_overflow=1. Draining gives the first 4 in order. ovf_clear then clears the flag.
- Counter wrap: impulse at BCID 3562 -> tag 0. bcr asserted mid-stream -> next input is tagged 0. Reset mid-RISE -> no entry and all outputs 0.
